// File: rtl/alu_seq_if.sv
// Handshake, operand and flag signals of alu_seq; the tri-state result bus stays a module port.
interface alu_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [3:0]       mode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             done;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_neg;
    logic             flag_ovf;

    modport master (
        output start, mode, in_a, in_b,
        input  busy, done, flag_zero, flag_carry, flag_neg, flag_ovf
    );

    modport slave (
        input  start, mode, in_a, in_b,
        output busy, done, flag_zero, flag_carry, flag_neg, flag_ovf
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake, persistent Z/C/N/V flags and tri-state result bus.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode D); otherwise D is a NOP.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_if.slave         bus,
    input  logic             eo,
    inout  wire [WIDTH-1:0]  out
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBB = 4'h3,
        OP_INC = 4'h4, OP_DEC = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
        OP_XOR = 4'h8, OP_NOT = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
        OP_CMP = 4'hC, OP_MUL = 4'hD, OP_RSE = 4'hE, OP_RSF = 4'hF
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] r_out;
    logic             z_q, c_q, n_q, v_q;
    logic             done_q;

    logic [WIDTH-1:0] add_b, sub_b;
    logic             add_cin, sub_cin;
    logic [WIDTH:0]   add_w, sub_w;
    logic             add_v, sub_v;

    logic [WIDTH-1:0] res;
    logic             wr_r, upd_zn;
    logic             nx_z, nx_c, nx_n, nx_v;

    assign op = op_e'(bus.mode);
    assign a  = bus.in_a;
    assign b  = bus.in_b;

    // One adder and one subtractor shared by ADD/ADC/INC and SUB/SBB/CMP/DEC.
    always_comb begin
        add_b   = b;
        add_cin = 1'b0;
        sub_b   = b;
        sub_cin = 1'b0;
        case (op)
            OP_ADC:  add_cin = c_q;
            OP_SBB:  sub_cin = c_q;
            OP_INC:  add_b   = WIDTH'(1);
            OP_DEC:  sub_b   = WIDTH'(1);
            default: ;
        endcase
    end

    assign add_w = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign sub_w = {1'b0, a} - {1'b0, sub_b} - {{WIDTH{1'b0}}, sub_cin};
    assign add_v = (a[MSB] == add_b[MSB]) && (add_w[MSB] != a[MSB]);
    assign sub_v = (a[MSB] != sub_b[MSB]) && (sub_w[MSB] != a[MSB]);

    always_comb begin
        res    = r_out;
        wr_r   = 1'b0;
        upd_zn = 1'b0;
        nx_z   = z_q;
        nx_c   = c_q;
        nx_n   = n_q;
        nx_v   = v_q;
        case (op)
            OP_ADD, OP_ADC: begin
                res = add_w[MSB:0]; wr_r = 1'b1; upd_zn = 1'b1;
                nx_c = add_w[WIDTH]; nx_v = add_v;
            end
            OP_SUB, OP_SBB: begin
                res = sub_w[MSB:0]; wr_r = 1'b1; upd_zn = 1'b1;
                nx_c = sub_w[WIDTH]; nx_v = sub_v;
            end
            OP_CMP: begin
                res = sub_w[MSB:0]; upd_zn = 1'b1;
                nx_c = sub_w[WIDTH]; nx_v = sub_v;
            end
            OP_INC: begin
                res = add_w[MSB:0]; wr_r = 1'b1; upd_zn = 1'b1; nx_v = add_v;
            end
            OP_DEC: begin
                res = sub_w[MSB:0]; wr_r = 1'b1; upd_zn = 1'b1; nx_v = sub_v;
            end
            OP_AND: begin
                res = a & b; wr_r = 1'b1; upd_zn = 1'b1; nx_c = 1'b0; nx_v = 1'b0;
            end
            OP_OR: begin
                res = a | b; wr_r = 1'b1; upd_zn = 1'b1; nx_c = 1'b0; nx_v = 1'b0;
            end
            OP_XOR: begin
                res = a ^ b; wr_r = 1'b1; upd_zn = 1'b1; nx_c = 1'b0; nx_v = 1'b0;
            end
            OP_NOT: begin
                res = ~a; wr_r = 1'b1; upd_zn = 1'b1; nx_c = 1'b0; nx_v = 1'b0;
            end
            OP_SHL: begin
                res = {a[MSB-1:0], 1'b0}; wr_r = 1'b1; upd_zn = 1'b1;
                nx_c = a[MSB]; nx_v = 1'b0;
            end
            OP_SHR: begin
                res = {1'b0, a[MSB:1]}; wr_r = 1'b1; upd_zn = 1'b1;
                nx_c = a[0]; nx_v = 1'b0;
            end
            default: ;
        endcase
        if (upd_zn) begin
            nx_z = (res == '0);
            nx_n = res[MSB];
        end
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e             state;
    logic               busy_q;
    logic [2*WIDTH-1:0] mul_acc, mul_a, mul_sum;
    logic [WIDTH-1:0]   mul_b;
    logic [CNT_W-1:0]   mul_cnt;
    logic               mul_last;

    // The final partial product is folded in combinationally so the result lands exactly WIDTH edges after start.
    assign mul_sum  = mul_acc + (mul_b[0] ? mul_a : '0);
    assign mul_last = (mul_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r_out   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            mul_acc <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_cnt <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (op == OP_MUL) begin
                            state   <= S_MUL;
                            busy_q  <= 1'b1;
                            mul_acc <= '0;
                            mul_a   <= {{WIDTH{1'b0}}, a};
                            mul_b   <= b;
                            mul_cnt <= '0;
                        end else begin
                            done_q <= 1'b1;
                            if (wr_r) r_out <= res;
                            z_q <= nx_z;
                            c_q <= nx_c;
                            n_q <= nx_n;
                            v_q <= nx_v;
                        end
                    end
                end
                S_MUL: begin
                    mul_acc <= mul_sum;
                    mul_a   <= mul_a << 1;
                    mul_b   <= mul_b >> 1;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_last) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        r_out  <= mul_sum[MSB:0];
                        z_q    <= (mul_sum[MSB:0] == '0);
                        n_q    <= mul_sum[MSB];
                        c_q    <= |mul_sum[2*WIDTH-1:WIDTH];
                        v_q    <= |mul_sum[2*WIDTH-1:WIDTH];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            r_out  <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            done_q <= bus.start;
            if (bus.start) begin
                if (wr_r) r_out <= res;
                z_q <= nx_z;
                c_q <= nx_c;
                n_q <= nx_n;
                v_q <= nx_v;
            end
        end
    end

    assign bus.busy = 1'b0;
`endif

    assign bus.done       = done_q;
    assign bus.flag_zero  = z_q;
    assign bus.flag_carry = c_q;
    assign bus.flag_neg   = n_q;
    assign bus.flag_ovf   = v_q;

    // Reset forces the bus value to zero immediately, before the register has cleared.
    assign out = eo ? (rst ? '0 : r_out) : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8; follows ALU_SEQ_MUL_EN to pick MUL or NOP expectations.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         eo;
    logic         tb_drv;
    logic [W-1:0] tb_val;
    wire  [W-1:0] out_bus;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {R, Z, C, N, V}
    logic [11:0] sb[$];
    logic [11:0] exp_v;
    logic [7:0]  m_r;
    logic        m_z, m_c, m_n, m_v;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus_if ();

    assign out_bus = tb_drv ? tb_val : {W{1'bz}};

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .eo  (eo),
        .out (out_bus)
    );

    function automatic logic [11:0] observed();
        return {out_bus, bus_if.flag_zero, bus_if.flag_carry, bus_if.flag_neg, bus_if.flag_ovf};
    endfunction

    function automatic bit ovf8(input int v);
        return (v > 127) || (v < -128);
    endfunction

    task automatic model_reset();
        m_r = '0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
        sb.delete();
    endtask

    task automatic model_push(input logic [3:0] md, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sbv, cin, s, ss;
        logic [7:0] res;
        bit wr, zn;
        ua = a; ub = b; sa = $signed(a); sbv = $signed(b);
        cin = 0; wr = 1'b0; zn = 1'b0; res = m_r; s = 0;
        case (md)
            4'h0, 4'h1: begin
                cin = (md == 4'h1) ? int'(m_c) : 0;
                s = ua + ub + cin; res = s[7:0]; m_c = (s > 255);
                m_v = ovf8(sa + sbv + cin); wr = 1'b1; zn = 1'b1;
            end
            4'h2, 4'h3, 4'hC: begin
                cin = (md == 4'h3) ? int'(m_c) : 0;
                s = ua - ub - cin; res = s[7:0]; m_c = (s < 0);
                m_v = ovf8(sa - sbv - cin); wr = (md != 4'hC); zn = 1'b1;
            end
            4'h4: begin s = ua + 1; res = s[7:0]; m_v = ovf8(sa + 1); wr = 1'b1; zn = 1'b1; end
            4'h5: begin s = ua - 1; res = s[7:0]; m_v = ovf8(sa - 1); wr = 1'b1; zn = 1'b1; end
            4'h6: begin res = a & b; m_c = 1'b0; m_v = 1'b0; wr = 1'b1; zn = 1'b1; end
            4'h7: begin res = a | b; m_c = 1'b0; m_v = 1'b0; wr = 1'b1; zn = 1'b1; end
            4'h8: begin res = a ^ b; m_c = 1'b0; m_v = 1'b0; wr = 1'b1; zn = 1'b1; end
            4'h9: begin res = ~a;    m_c = 1'b0; m_v = 1'b0; wr = 1'b1; zn = 1'b1; end
            4'hA: begin s = ua * 2; res = s[7:0]; m_c = (ua >= 128); m_v = 1'b0; wr = 1'b1; zn = 1'b1; end
            4'hB: begin s = ua / 2; res = s[7:0]; m_c = (ua % 2 == 1); m_v = 1'b0; wr = 1'b1; zn = 1'b1; end
`ifdef ALU_SEQ_MUL_EN
            4'hD: begin
                s = ua * ub; res = s[7:0]; m_c = ((s / 256) != 0); m_v = m_c; wr = 1'b1; zn = 1'b1;
            end
`endif
            default: ;
        endcase
        if (zn) begin m_z = (res == 8'h00); m_n = res[7]; end
        if (wr) m_r = res;
        sb.push_back({m_r, m_z, m_c, m_n, m_v});
    endtask

    // Pulses start for one accepted single-cycle op; returns 1ns after the capturing edge.
    task automatic op1(input logic [3:0] md, input logic [7:0] a, input logic [7:0] b);
        bus_if.start = 1'b1; bus_if.mode = md; bus_if.in_a = a; bus_if.in_b = b;
        model_push(md, a, b);
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; eo = 1'b1; tb_drv = 1'b0; tb_val = '0;
        bus_if.start = 1'b0; bus_if.mode = '0; bus_if.in_a = '0; bus_if.in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_tests++;
        if (observed() !== 12'h000 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got r/zcnv=%h busy=%b done=%b want 000 busy=0 done=0",
                     observed(), bus_if.busy, bus_if.done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_adc();
        op1(4'h0, 8'hFF, 8'h01);
        exp_v = sb.pop_front();
        n_tests++;
        if (bus_if.done !== 1'b1 || observed() !== exp_v) begin
            n_fail++;
            $display("FAIL add_ff_01: got done=%b r/zcnv=%h want done=1 %h", bus_if.done, observed(), exp_v);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: got done=%b want 0", bus_if.done);
        end
        op1(4'h1, 8'h10, 8'h20);
        exp_v = sb.pop_front();
        n_tests++;
        if (bus_if.done !== 1'b1 || observed() !== exp_v) begin
            n_fail++;
            $display("FAIL adc_10_20: got done=%b r/zcnv=%h want done=1 %h", bus_if.done, observed(), exp_v);
        end
    endtask

    task automatic test_sub_cmp();
        op1(4'h2, 8'h05, 8'h07);
        exp_v = sb.pop_front();
        n_tests++;
        if (bus_if.done !== 1'b1 || observed() !== exp_v) begin
            n_fail++;
            $display("FAIL sub_05_07: got done=%b r/zcnv=%h want done=1 %h", bus_if.done, observed(), exp_v);
        end
        op1(4'hC, 8'h80, 8'h01);
        exp_v = sb.pop_front();
        n_tests++;
        if (bus_if.done !== 1'b1 || observed() !== exp_v) begin
            n_fail++;
            $display("FAIL cmp_80_01: got done=%b r/zcnv=%h want done=1 %h", bus_if.done, observed(), exp_v);
        end
    endtask

    task automatic test_shift_bus();
        logic [3:0] mds[3] = '{4'hA, 4'hB, 4'h7};
        logic [7:0] as[3]  = '{8'h81, 8'h01, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            op1(mds[i], as[i], 8'h00);
            exp_v = sb.pop_front();
            n_tests++;
            if (bus_if.done !== 1'b1 || observed() !== exp_v) begin
                n_fail++;
                $display("FAIL shift_op%0d: got done=%b r/zcnv=%h want done=1 %h", i, bus_if.done, observed(), exp_v);
            end
        end
        // With eo low the bench drives a value disjoint from R; any DUT drive would corrupt it.
        eo = 1'b0; tb_val = ~m_r; tb_drv = 1'b1;
        #1;
        n_tests++;
        if (out_bus !== ~m_r) begin
            n_fail++;
            $display("FAIL bus_release: got out=%h want %h (DUT released)", out_bus, ~m_r);
        end
        tb_drv = 1'b0; eo = 1'b1;
        #1;
        n_tests++;
        if (out_bus !== m_r) begin
            n_fail++;
            $display("FAIL bus_drive: got out=%h want %h", out_bus, m_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_corners();
        logic [3:0] mds[9] = '{4'h4, 4'h5, 4'h4, 4'h9, 4'h8, 4'h6, 4'hE, 4'hF, 4'h3};
        logic [7:0] as[9]  = '{8'hFF, 8'h00, 8'h7F, 8'h5A, 8'hF0, 8'h0F, 8'h12, 8'h34, 8'h00};
        logic [7:0] bs[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0, 8'h56, 8'h78, 8'h00};
        for (int i = 0; i < 9; i++) begin
            op1(mds[i], as[i], bs[i]);
            exp_v = sb.pop_front();
            n_tests++;
            if (bus_if.done !== 1'b1 || observed() !== exp_v) begin
                n_fail++;
                $display("FAIL corner%0d_op%h: got done=%b r/zcnv=%h want done=1 %h",
                         i, mds[i], bus_if.done, observed(), exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] md;
        logic [7:0] a, b;
        bus_if.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            md = 4'($urandom_range(0, 15));
`ifdef ALU_SEQ_MUL_EN
            if (md == 4'hD) md = 4'h1;
`endif
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            bus_if.mode = md; bus_if.in_a = a; bus_if.in_b = b;
            model_push(md, a, b);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_tests++;
            if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0 || observed() !== exp_v) begin
                n_fail++;
                $display("FAIL b2b%0d_op%h a=%h b=%h: got done=%b busy=%b r/zcnv=%h want done=1 busy=0 %h",
                         i, md, a, b, bus_if.done, bus_if.busy, observed(), exp_v);
            end
        end
        bus_if.start = 1'b0;
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul();
        int k;
        bit seen;
        op1(4'hD, 8'h12, 8'h10);
        n_tests++;
        if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_busy_start: got busy=%b done=%b want busy=1 done=0", bus_if.busy, bus_if.done);
        end
        seen = 1'b0; k = 0;
        while (!seen && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (bus_if.done === 1'b1) seen = 1'b1;
            if (k == 2) begin
                bus_if.start = 1'b1; bus_if.mode = 4'h0; bus_if.in_a = 8'hFF; bus_if.in_b = 8'hFF;
            end
            if (k == 3) bus_if.start = 1'b0;
        end
        bus_if.start = 1'b0;
        exp_v = sb.pop_front();
        n_tests++;
        if (!seen || k != W || bus_if.busy !== 1'b0 || observed() !== exp_v) begin
            n_fail++;
            $display("FAIL mul_12_10: got done_seen=%b cycles=%0d busy=%b r/zcnv=%h want seen=1 cycles=%0d busy=0 %h",
                     seen, k, bus_if.busy, observed(), W, exp_v);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus_if.done !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL mul_done_pulse: got done=%b pending=%0d want done=0 pending=0", bus_if.done, sb.size());
        end
        op1(4'h1, 8'h01, 8'h01);
        exp_v = sb.pop_front();
        n_tests++;
        if (bus_if.done !== 1'b1 || observed() !== exp_v) begin
            n_fail++;
            $display("FAIL adc_after_mul: got done=%b r/zcnv=%h want done=1 %h", bus_if.done, observed(), exp_v);
        end
    endtask

    task automatic test_mul_reset();
        bit stray;
        op1(4'h0, 8'hFF, 8'h01);
        void'(sb.pop_front());
        op1(4'hD, 8'h12, 8'h10);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_bus !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_bus_zero: got out=%h want 00", out_bus);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_tests++;
        if (observed() !== 12'h000 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_reset: got r/zcnv=%h busy=%b done=%b want 000 busy=0 done=0",
                     observed(), bus_if.busy, bus_if.done);
        end
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) stray = 1'b1;
        end
        n_tests++;
        if (stray) begin
            n_fail++;
            $display("FAIL mul_reset_quiet: got done/busy activity after reset want none");
        end
    endtask
`else
    task automatic test_mul_disabled();
        bus_if.start = 1'b1; bus_if.mode = 4'hD; bus_if.in_a = 8'h12; bus_if.in_b = 8'h10;
        model_push(4'hD, 8'h12, 8'h10);
        #1;
        n_tests++;
        if (bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nomul_busy: got busy=%b want 0", bus_if.busy);
        end
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        exp_v = sb.pop_front();
        n_tests++;
        if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0 || observed() !== exp_v) begin
            n_fail++;
            $display("FAIL nomul_nop: got done=%b busy=%b r/zcnv=%h want done=1 busy=0 %h",
                     bus_if.done, bus_if.busy, observed(), exp_v);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add_adc();
        test_sub_cmp();
        test_shift_bus();
        test_corners();
        test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
